// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encodings for the UART TX arbiter
package uart_pkg;

    localparam logic [7:0] SYNC0_DEFAULT = 8'h99;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h24;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_HDR0 = 3'd2,
        ST_HDR1 = 3'd3,
        ST_PAY  = 3'd4,
        ST_CKS  = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    // Every transmitting state first launches a byte, then waits for the UART to finish it.
    typedef enum logic {
        PH_SEND = 1'b0,
        PH_WAIT = 1'b1
    } phase_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o
);

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        pick_o = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin frame arbiter wrapping payloads with sync header and XOR checksum
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         NUM_REQ = 2,
    parameter logic [7:0] SYNC0   = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1   = SYNC1_DEFAULT,
    parameter int         MAX_LEN = 16
) (
    input  logic                   clk_50m,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   frame_done,
    output logic                   frame_trunc,
    output logic [7:0]             uart_tx_data,
    output logic                   uart_tx_en,
    input  logic                   uart_tx_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

    state_e              state_q, state_d;
    phase_e              phase_q, phase_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]       gidx_q, gidx_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [7:0]          cks_q, cks_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                trunc_q, trunc_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_en_q, tx_en_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic                done_q, done_d;
    logic                trunc_out_q, trunc_out_d;

    logic [NUM_REQ-1:0]  pick;
    logic [7:0]          req_byte;

    function automatic logic [PW-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick)
    );

    assign req_byte = req_data[8*gidx_q +: 8];

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cks_d       = cks_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        trunc_d     = trunc_q;
        tx_data_d   = tx_data_q;
        tx_en_d     = 1'b0;
        ready_d     = '0;
        done_d      = 1'b0;
        trunc_out_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                // A request that vanished between IDLE and ARB leaves pick empty; fall back to IDLE.
                gnt_d   = pick;
                gidx_d  = onehot_to_idx(pick);
                cks_d   = '0;
                cnt_d   = '0;
                last_d  = 1'b0;
                trunc_d = 1'b0;
                phase_d = PH_SEND;
                state_d = (|pick) ? ST_HDR0 : ST_IDLE;
            end
            ST_HDR0, ST_HDR1, ST_CKS: begin
                if (phase_q == PH_SEND) begin
                    tx_data_d = (state_q == ST_HDR0) ? SYNC0 :
                                (state_q == ST_HDR1) ? SYNC1 : cks_q;
                    tx_en_d   = 1'b1;
                    phase_d   = PH_WAIT;
                end else if (uart_tx_done) begin
                    phase_d = PH_SEND;
                    state_d = (state_q == ST_HDR0) ? ST_HDR1 :
                              (state_q == ST_HDR1) ? ST_PAY  : ST_DONE;
                end
            end
            ST_PAY: begin
                if (phase_q == PH_SEND) begin
                    if (req_valid[gidx_q]) begin
                        tx_data_d = req_byte;
                        tx_en_d   = 1'b1;
                        ready_d   = gnt_q;
                        cks_d     = cks_q ^ req_byte;
                        cnt_d     = cnt_q + 1'b1;
                        last_d    = req_last[gidx_q] | (cnt_q == LAST_CNT);
                        trunc_d   = !req_last[gidx_q] && (cnt_q == LAST_CNT);
                        phase_d   = PH_WAIT;
                    end
                end else if (uart_tx_done) begin
                    phase_d = PH_SEND;
                    state_d = last_q ? ST_CKS : ST_PAY;
                end
            end
            ST_DONE: begin
                done_d      = 1'b1;
                trunc_out_d = trunc_q;
                gnt_d       = '0;
                ptr_d       = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
                phase_d     = PH_SEND;
                state_d     = ST_IDLE;
            end
            default: begin
                phase_d = PH_SEND;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_SEND;
            gnt_q       <= '0;
            gidx_q      <= '0;
            ptr_q       <= '0;
            cks_q       <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            trunc_q     <= 1'b0;
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
            ready_q     <= '0;
            done_q      <= 1'b0;
            trunc_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            cks_q       <= cks_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            trunc_q     <= trunc_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            trunc_out_q <= trunc_out_d;
        end
    end

    assign gnt          = gnt_q;
    assign req_ready    = ready_q;
    assign frame_done   = done_q;
    assign frame_trunc  = trunc_out_q;
    assign uart_tx_data = tx_data_q;
    assign uart_tx_en   = tx_en_q;

endmodule
